// File: rtl/cp_insert_pp.sv
// Cyclic-prefix inserter: ping-pong symbol buffer. Each N-sample symbol is replayed
// as its last cp samples followed by all N samples, with input backpressure and framing flags.
module cp_insert_pp #(
  parameter int DW        = 20,
  parameter int NFFT_LOG2 = 10,
  parameter int CP_MAX    = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NFFT_LOG2:0]   cp_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sop,
  input  logic [DW-1:0]        in_i,
  input  logic [DW-1:0]        in_q,
  output logic                 out_valid,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [DW-1:0]        out_i,
  output logic [DW-1:0]        out_q,
  output logic                 err
);
  localparam int AW = NFFT_LOG2;
  localparam int N  = 1 << AW;
  localparam logic [AW:0]   NV   = (AW+1)'(N);
  localparam logic [AW:0]   CPM  = (AW+1)'(CP_MAX);
  localparam logic [AW-1:0] LAST = AW'(N-1);

  typedef enum logic [1:0] {S_IDLE, S_CP, S_BODY} state_t;

  logic [2*DW-1:0] mem [2*N];

  logic              wbank_q, wbank_d, wopen_q, wopen_d;
  logic              rbank_q, rbank_d, err_q, err_d;
  logic [AW-1:0]     waddr_q, waddr_d, raddr_q, raddr_d;
  logic [1:0]        full_q, full_d;
  logic [1:0][AW:0]  cp_q, cp_d;
  state_t            state_q, state_d;

  logic              accept, wr_en, iss, iss_sop, iss_eop;
  logic [AW-1:0]     wr_addr, start_cur, start_nxt;
  logic [AW:0]       cp_sat, cp_cur, cp_nxt;

  logic              v1_q, s1_q, e1_q, ov_q, os_q, oe_q;
  logic [2*DW-1:0]   rd_q;
  logic [DW-1:0]     oi_q, oq_q;

  assign in_ready  = ~full_q[wbank_q];
  assign accept    = in_valid & in_ready & en;
  assign cp_sat    = (cp_len > CPM) ? CPM : cp_len;
  assign cp_cur    = cp_q[rbank_q];
  assign cp_nxt    = cp_q[~rbank_q];
  assign start_cur = AW'(NV - cp_cur);
  assign start_nxt = AW'(NV - cp_nxt);

  always_comb begin
    wbank_d = wbank_q;
    waddr_d = waddr_q;
    wopen_d = wopen_q;
    full_d  = full_q;
    cp_d    = cp_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = waddr_q;
    state_d = state_q;
    rbank_d = rbank_q;
    raddr_d = raddr_q;
    iss     = (state_q != S_IDLE);
    iss_sop = ((state_q == S_CP) && (raddr_q == start_cur)) ||
              ((state_q == S_BODY) && (raddr_q == '0) && (cp_cur == '0));
    iss_eop = (state_q == S_BODY) && (raddr_q == LAST);

    // A sop while a symbol is open abandons it and restarts in the same bank.
    if (accept) begin
      if (in_sop) begin
        wr_en          = 1'b1;
        wr_addr        = '0;
        waddr_d        = AW'(1);
        wopen_d        = 1'b1;
        cp_d[wbank_q]  = cp_sat;
        err_d          = wopen_q;
      end else if (wopen_q) begin
        wr_en = 1'b1;
        if (waddr_q == LAST) begin
          wopen_d         = 1'b0;
          waddr_d         = '0;
          full_d[wbank_q] = 1'b1;
          wbank_d         = ~wbank_q;
        end else begin
          waddr_d = waddr_q + AW'(1);
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (full_q[rbank_q]) begin
          if (cp_cur != '0) begin
            state_d = S_CP;
            raddr_d = start_cur;
          end else begin
            state_d = S_BODY;
            raddr_d = '0;
          end
        end
      end
      S_CP: begin
        if (raddr_q == LAST) begin
          state_d = S_BODY;
          raddr_d = '0;
        end else begin
          raddr_d = raddr_q + AW'(1);
        end
      end
      S_BODY: begin
        if (raddr_q == LAST) begin
          // Free this bank; chain straight into the other one if it is ready.
          full_d[rbank_q] = 1'b0;
          rbank_d         = ~rbank_q;
          raddr_d         = '0;
          if (full_q[~rbank_q]) begin
            if (cp_nxt != '0) begin
              state_d = S_CP;
              raddr_d = start_nxt;
            end else begin
              state_d = S_BODY;
            end
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          raddr_d = raddr_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbank_q <= 1'b0;
      waddr_q <= '0;
      wopen_q <= 1'b0;
      full_q  <= '0;
      cp_q    <= '0;
      err_q   <= 1'b0;
      state_q <= S_IDLE;
      rbank_q <= 1'b0;
      raddr_q <= '0;
    end else if (en) begin
      wbank_q <= wbank_d;
      waddr_q <= waddr_d;
      wopen_q <= wopen_d;
      full_q  <= full_d;
      cp_q    <= cp_d;
      err_q   <= err_d;
      state_q <= state_d;
      rbank_q <= rbank_d;
      raddr_q <= raddr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wbank_q, wr_addr}] <= {in_i, in_q};
  end

  // Two-stage read: registered RAM output, then registered sample outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      s1_q <= 1'b0;
      e1_q <= 1'b0;
      rd_q <= '0;
      ov_q <= 1'b0;
      os_q <= 1'b0;
      oe_q <= 1'b0;
      oi_q <= '0;
      oq_q <= '0;
    end else if (en) begin
      v1_q <= iss;
      s1_q <= iss_sop;
      e1_q <= iss_eop;
      if (iss) rd_q <= mem[{rbank_q, raddr_q}];
      ov_q <= v1_q;
      os_q <= s1_q;
      oe_q <= e1_q;
      if (v1_q) {oi_q, oq_q} <= rd_q;
    end
  end

  assign out_valid = ov_q & en;
  assign out_sop   = os_q & en;
  assign out_eop   = oe_q & en;
  assign err       = err_q & en;
  assign out_i     = oi_q;
  assign out_q     = oq_q;

endmodule

// File: tb/tb_cp_insert_pp.sv
// Bench for cp_insert_pp: directed cases plus random traffic, checked against a
// symbol-level queue model of the expected CP-prefixed output stream.
module tb_cp_insert_pp;
  localparam int DW = 20, NL = 4, CPM = 8;
  localparam int N = 1 << NL;

  logic clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic [NL:0] cp_len = '0;
  logic in_valid = 1'b0, in_sop = 1'b0, in_ready;
  logic [DW-1:0] in_i = '0, in_q = '0, out_i, out_q;
  logic out_valid, out_sop, out_eop, err;

  cp_insert_pp #(.DW(DW), .NFFT_LOG2(NL), .CP_MAX(CPM)) dut (
    .clk(clk), .rst(rst), .en(en), .cp_len(cp_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
    .in_i(in_i), .in_q(in_q),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_i(out_i), .out_q(out_q), .err(err));

  always #5 clk = ~clk;

  typedef struct {logic [DW-1:0] i, q; bit sop, eop;} smp_t;
  smp_t exp_q[$];

  int nchk = 0, nerr = 0;
  bit en_rand = 0, en_man = 1;
  bit open = 0, err_due = 0, in_sym = 0;
  int idx = 0, cps = 0, run = 0, maxrun = 0, err_seen = 0;
  logic [DW-1:0] sb_i [N], sb_q [N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    en = en_rand ? ($urandom_range(0, 4) != 0) : en_man;
  end

  // Model: a completed symbol becomes its last cp samples then all N samples.
  always @(negedge clk) begin
    smp_t e;
    if (en) begin
      chk("err", err, err_due);
      err_due = 0;
      if (err) err_seen++;
      if (in_sym) chk("cont", out_valid, 1);
      if (out_valid) begin
        if (exp_q.size() == 0) chk("extra", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_i", out_i, e.i);
          chk("out_q", out_q, e.q);
          chk("sop", out_sop, e.sop);
          chk("eop", out_eop, e.eop);
        end
        if (out_sop) in_sym = 1;
        if (out_eop) in_sym = 0;
        run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
    end else begin
      chk("frz", {out_valid, out_sop, out_eop, err}, 0);
    end
    if (in_valid && in_ready && en && !rst) begin
      if (in_sop) begin
        if (open) err_due = 1;
        open = 1;
        sb_i[0] = in_i; sb_q[0] = in_q; idx = 1;
        cps = (int'(cp_len) > CPM) ? CPM : int'(cp_len);
      end else if (open) begin
        sb_i[idx] = in_i; sb_q[idx] = in_q; idx++;
        if (idx == N) begin
          for (int k = 0; k < cps + N; k++) begin
            int j;
            j = (k < cps) ? N - cps + k : k - cps;
            e.i = sb_i[j]; e.q = sb_q[j];
            e.sop = (k == 0); e.eop = (k == cps + N - 1);
            exp_q.push_back(e);
          end
          open = 0;
        end
      end
    end
    if (rst) begin
      exp_q.delete();
      open = 0; err_due = 0; in_sym = 0; run = 0;
    end
  end

  task automatic send(input logic [DW-1:0] di, input logic [DW-1:0] dq, input bit sop);
    int t;
    in_valid = 1; in_i = di; in_q = dq; in_sop = sop; t = 0;
    forever begin
      @(negedge clk);
      if (in_ready && en) break;
      t++;
      if (t > 3000) begin
        $display("FAIL stall: in_ready never rose");
        $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
        $fatal(1);
      end
    end
    @(posedge clk); #1;
    in_valid = 0; in_sop = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic sym(input int cl, input int gaps);
    cp_len = cl[NL:0];
    for (int s = 0; s < N; s++) begin
      if (gaps != 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send(DW'($urandom), DW'($urandom), s == 0);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || in_sym) && t < 3000) begin idle(1); t++; end
    chk("drain", t < 3000, 1);
    idle(4);
  endtask

  task automatic wait_sop();
    int t = 0;
    do begin idle(1); t++; end while (!out_sop && t < 200);
    chk("sop_tmo", out_sop, 1);
  endtask

  initial begin
    int e0;
    idle(3);
    rst = 0;
    chk("rst_rdy", in_ready, 1);
    chk("rst_out", {out_valid, out_sop, out_eop, err}, 0);
    chk("rst_i", out_i, 0);
    chk("rst_q", out_q, 0);

    // 1: cp=4, I=0..15, Q=-I, plus first-output latency
    cp_len = 4;
    for (int s = 0; s < N; s++) send(DW'(s), DW'(-s), s == 0);
    chk("lat0", out_valid, 0);
    idle(1); chk("lat1", out_valid, 0);
    idle(1); chk("lat2", out_valid, 0);
    idle(1); chk("lat3", out_valid, 1);
    chk("lat3_i", out_i, 12);
    drain();

    // 2: four symbols back-to-back, valid held
    maxrun = 0;
    begin
      bit saw_low = 0;
      cp_len = 4;
      for (int k = 0; k < 4; k++)
        for (int s = 0; s < N; s++) begin
          send(DW'($urandom), DW'($urandom), s == 0);
          if (!in_ready) saw_low = 1;
        end
      chk("rdy_low", saw_low, 1);
    end
    drain();
    chk("run80", maxrun, 80);

    // 3: cp=0
    maxrun = 0;
    sym(0, 0);
    drain();
    chk("run16", maxrun, 16);

    // 4: restart at sample 7
    e0 = err_seen;
    cp_len = 4;
    for (int s = 0; s < 7; s++) send(DW'(100 + s), DW'(200 + s), s == 0);
    sym(4, 0);
    drain();
    chk("err1", err_seen - e0, 1);

    // 5: reset mid-CP
    sym(4, 0);
    wait_sop();
    idle(1);
    rst = 1;
    idle(1);
    rst = 0;
    chk("mrst_out", {out_valid, out_sop, out_eop, err}, 0);
    chk("mrst_i", out_i, 0);
    chk("mrst_rdy", in_ready, 1);
    idle(3);
    chk("mrst_quiet", out_valid, 0);
    sym(4, 0);
    drain();

    // 6: cp_len beyond CP_MAX, en low 3 cycles mid-body
    cp_len = 15;
    for (int s = 0; s < N; s++) send(DW'(s), DW'(-s), s == 0);
    wait_sop();
    idle(12);
    en_man = 0;
    idle(3);
    en_man = 1;
    drain();

    // random traffic: gaps, en drops, junk, restarts, random cp
    en_rand = 1;
    for (int k = 0; k < 14; k++) begin
      int cl;
      cl = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) begin
        send(DW'($urandom), DW'($urandom), 0);
        send(DW'($urandom), DW'($urandom), 0);
      end
      if ($urandom_range(0, 3) == 0) begin
        cp_len = cl[NL:0];
        for (int s = 0; s < int'($urandom_range(2, 14)); s++)
          send(DW'($urandom), DW'($urandom), s == 0);
      end
      sym(cl, 1);
    end
    en_rand = 0;
    idle(3);
    drain();
    chk("left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
